// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the lock state type shared by the
// VGA sync decoder and its sub-modules.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE   = 640;
    localparam int DEF_H_FRONT     = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BACK      = 48;
    localparam int DEF_V_VISIBLE   = 480;
    localparam int DEF_V_FRONT     = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BACK      = 33;
    localparam int DEF_LOCK_FRAMES = 2;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers an active-low sync input once and flags its falling and rising
// edges from the registered value and its previous value.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sync,
    output logic fall,
    output logic rise
);

    logic sync_reg;
    logic prev_reg;

    // Reset to the idle (high) level so an idle line produces no edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= sync;
            prev_reg <= sync_reg;
        end
    end

    assign fall = prev_reg & ~sync_reg;
    assign rise = ~prev_reg & sync_reg;

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds raster position from HSync/VSync, checks line/frame/pulse timing
// and tracks lock over consecutive clean frames.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = DEF_H_VISIBLE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_VISIBLE   = DEF_V_VISIBLE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       HSync,
    input  logic       VSync,
    output logic [9:0] row,
    output logic [9:0] col,
    output logic       active,
    output logic       frame_start,
    output logic       locked,
    output logic       h_err,
    output logic       v_err
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
    localparam logic [9:0] H_START     = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END       = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_START     = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END       = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
    localparam logic [9:0] CNT_MAX     = 10'd1023;
    localparam logic [9:0] CNT_PRE     = 10'd1022;
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_FRAMES - 1);

    logic h_fall, h_rise, v_fall, v_rise_unused;

    sync_edge_detect u_hsync_edge (
        .clk   (clk),
        .reset (reset),
        .sync  (HSync),
        .fall  (h_fall),
        .rise  (h_rise)
    );

    sync_edge_detect u_vsync_edge (
        .clk   (clk),
        .reset (reset),
        .sync  (VSync),
        .fall  (v_fall),
        .rise  (v_rise_unused)
    );

    logic [9:0]    hcount_reg, vcount_reg;
    logic          h_armed_reg, v_armed_reg, vsync_pend_reg;
    logic [9:0]    row_reg, col_reg;
    logic          active_reg, frame_start_reg, h_err_reg, v_err_reg, locked_reg;
    lock_state_t   state_reg;
    logic [GW-1:0] good_cnt_reg;

    logic frame_reset, h_err_next, v_err_next, err_any, h_vis, v_vis;

    assign frame_reset = h_fall & vsync_pend_reg;
    assign h_vis       = (hcount_reg >= H_START) && (hcount_reg <= H_END);
    assign v_vis       = (vcount_reg >= V_START) && (vcount_reg <= V_END);

    // Saturation is flagged on the step into 1023, so it fires exactly once.
    always_comb begin
        h_err_next = 1'b0;
        v_err_next = 1'b0;
        if (h_fall && h_armed_reg && (hcount_reg != H_LAST))
            h_err_next = 1'b1;
        if (h_rise && (hcount_reg != H_SYNC_LAST))
            h_err_next = 1'b1;
        if (!h_fall && (hcount_reg == CNT_PRE))
            h_err_next = 1'b1;
        if (frame_reset && v_armed_reg && (vcount_reg != V_LAST))
            v_err_next = 1'b1;
        if (h_fall && !vsync_pend_reg && (vcount_reg == CNT_PRE))
            v_err_next = 1'b1;
    end

    assign err_any = h_err_next | v_err_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcount_reg      <= '0;
            vcount_reg      <= '0;
            h_armed_reg     <= 1'b0;
            v_armed_reg     <= 1'b0;
            vsync_pend_reg  <= 1'b0;
            row_reg         <= '0;
            col_reg         <= '0;
            active_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            h_err_reg       <= 1'b0;
            v_err_reg       <= 1'b0;
        end else begin
            if (h_fall) begin
                hcount_reg  <= '0;
                h_armed_reg <= 1'b1;
            end else if (hcount_reg != CNT_MAX) begin
                hcount_reg <= hcount_reg + 10'd1;
            end

            // VSync only takes effect at the next line start.
            if (h_fall) begin
                vsync_pend_reg <= v_fall;
                if (vsync_pend_reg) begin
                    vcount_reg  <= '0;
                    v_armed_reg <= 1'b1;
                end else if (vcount_reg != CNT_MAX) begin
                    vcount_reg <= vcount_reg + 10'd1;
                end
            end else if (v_fall) begin
                vsync_pend_reg <= 1'b1;
            end

            if (h_vis)
                col_reg <= hcount_reg - H_START;
            if (v_vis)
                row_reg <= vcount_reg - V_START;
            active_reg      <= h_vis && v_vis && (state_reg == LOCKED);
            frame_start_reg <= frame_reset;
            h_err_reg       <= h_err_next;
            v_err_reg       <= v_err_next;
        end
    end

    // Errors take priority over a lock-qualifying frame reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= UNLOCKED;
            good_cnt_reg <= '0;
            locked_reg   <= 1'b0;
        end else begin
            case (state_reg)
                UNLOCKED: begin
                    if (frame_reset) begin
                        state_reg    <= ACQUIRE;
                        good_cnt_reg <= '0;
                    end
                end
                ACQUIRE: begin
                    if (err_any) begin
                        state_reg <= UNLOCKED;
                    end else if (frame_reset) begin
                        good_cnt_reg <= good_cnt_reg + GW'(1);
                        if (good_cnt_reg == LOCK_LAST)
                            state_reg <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (err_any)
                        state_reg <= UNLOCKED;
                end
                default: state_reg <= UNLOCKED;
            endcase
            locked_reg <= (state_reg == LOCKED);
        end
    end

    assign row         = row_reg;
    assign col         = col_reg;
    assign active      = active_reg;
    assign frame_start = frame_start_reg;
    assign locked      = locked_reg;
    assign h_err       = h_err_reg;
    assign v_err       = v_err_reg;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Drives a sync generator with reduced timing into the decoder and compares
// position, visibility, lock and error pulses against a raster-position model.
module tb_vga_sync_decoder;

    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
    localparam int H_TOTAL = HV + HF + HS + HB;
    localparam int V_TOTAL = VV + VF + VS + VB;

    logic       clk, reset, HSync, VSync;
    logic [9:0] row, col;
    logic       active, frame_start, locked, h_err, v_err;

    vga_sync_decoder #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .HSync(HSync), .VSync(VSync),
        .row(row), .col(col), .active(active), .frame_start(frame_start),
        .locked(locked), .h_err(h_err), .v_err(v_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, failed = 0;
    int h_err_cnt, v_err_cnt, fs_cnt, pix_bad, act_cnt;
    bit unlock_pend = 1'b0;
    bit chk_cur = 1'b0;
    int hx[3], hy[3];
    bit hc[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit in_window(input int x, input int y);
        return (x >= HS + HB) && (x < HS + HB + HV) && (y >= VS + VB) && (y < VS + VB + VV);
    endfunction

    // Outputs seen now belong to the pixel driven three ticks earlier.
    task automatic sample();
        bit exp_act;
        if (h_err === 1'b1) h_err_cnt++;
        if (v_err === 1'b1) v_err_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
        if (unlock_pend) begin
            check("locked_drop_after_err", {31'd0, locked}, 32'd0);
            unlock_pend = 1'b0;
        end
        if ((h_err === 1'b1 || v_err === 1'b1) && locked === 1'b1) unlock_pend = 1'b1;
        if (hc[2]) begin
            exp_act = in_window(hx[2], hy[2]);
            if (active !== exp_act) pix_bad++;
            if (exp_act && (col !== 10'(hx[2] - HS - HB) || row !== 10'(hy[2] - VS - VB))) pix_bad++;
            if (active === 1'b1) act_cnt++;
        end
    endtask

    task automatic tick(input logic h, input logic v, input int x, input int y);
        @(posedge clk);
        #1;
        sample();
        HSync = h;
        VSync = v;
        hx[2] = hx[1]; hx[1] = hx[0]; hx[0] = x;
        hy[2] = hy[1]; hy[1] = hy[0]; hy[0] = y;
        hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = chk_cur;
    endtask

    task automatic send_line(input int y, input int x0, input int x1, input int len,
                             input int hs_low, input bit vtail);
        for (int x = x0; x <= x1; x++)
            tick(x >= hs_low, !(vtail && x >= len / 2), x, y);
    endtask

    task automatic send_frame(input int nlines, input int bad_len_y, input int bad_hs_y,
                              input int stop_y);
        int len, hsl;
        for (int y = 0; y < nlines; y++) begin
            len = (y == bad_len_y) ? H_TOTAL - 1 : H_TOTAL;
            hsl = (y == bad_hs_y) ? HS - 1 : HS;
            if (y == stop_y) begin
                send_line(y, 0, int'($urandom_range(len - 1)), len, hsl, 1'b0);
                return;
            end
            send_line(y, 0, len - 1, len, hsl, y == nlines - 1);
        end
    endtask

    task automatic checked_frame(input string tag);
        pix_bad = 0;
        act_cnt = 0;
        chk_cur = 1'b1;
        send_frame(V_TOTAL, -1, -1, -1);
        chk_cur = 1'b0;
        check({tag, "_pixels"}, pix_bad, 0);
        check({tag, "_active_cycles"}, act_cnt, HV * VV);
    endtask

    task automatic clear_counts();
        h_err_cnt = 0;
        v_err_cnt = 0;
        fs_cnt = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_row"}, {22'd0, row}, 0);
        check({tag, "_col"}, {22'd0, col}, 0);
        check({tag, "_active"}, {31'd0, active}, 0);
        check({tag, "_frame_start"}, {31'd0, frame_start}, 0);
        check({tag, "_locked"}, {31'd0, locked}, 0);
        check({tag, "_h_err"}, {31'd0, h_err}, 0);
        check({tag, "_v_err"}, {31'd0, v_err}, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, by, sy, x0;
        HSync = 1'b1; VSync = 1'b1; reset = 1'b1;
        for (int i = 0; i < 3; i++) begin hx[i] = -1; hy[i] = -1; hc[i] = 1'b0; end
        clear_counts();
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b1;

        // Acquire: tail line carrying VSync, then three clean frames.
        repeat (10) tick(1'b1, 1'b1, -1, -1);
        clear_counts();
        send_line(V_TOTAL - 1, 0, H_TOTAL - 1, H_TOTAL, HS, 1'b1);
        send_frame(V_TOTAL, -1, -1, -1);
        send_frame(V_TOTAL, -1, -1, -1);
        check("not_locked_after_2_frames", {31'd0, locked}, 0);
        checked_frame("first_locked_frame");
        check("frame_starts_3", fs_cnt, 3);
        check("locked_after_3", {31'd0, locked}, 1);
        check("acq_h_err", h_err_cnt, 0);
        check("acq_v_err", v_err_cnt, 0);

        n = int'($urandom_range(1, 2));
        for (int i = 0; i < n; i++) checked_frame("locked_frame");

        // One short line while locked.
        clear_counts();
        by = int'($urandom_range(1, V_TOTAL - 3));
        send_frame(V_TOTAL, by, -1, -1);
        check("short_line_h_err", h_err_cnt, 1);
        check("short_line_unlocked", {31'd0, locked}, 0);
        send_frame(V_TOTAL, -1, -1, -1);
        send_frame(V_TOTAL, -1, -1, -1);
        check("short_line_not_yet", {31'd0, locked}, 0);
        checked_frame("relock_line");
        check("short_line_relocked", {31'd0, locked}, 1);
        check("short_line_h_total", h_err_cnt, 1);
        check("short_line_v_err", v_err_cnt, 0);

        // Narrow HSync pulse, line length unchanged.
        clear_counts();
        by = int'($urandom_range(0, V_TOTAL - 1));
        send_frame(V_TOTAL, -1, by, -1);
        check("narrow_hs_h_err", h_err_cnt, 1);
        check("narrow_hs_v_err", v_err_cnt, 0);
        check("narrow_hs_unlocked", {31'd0, locked}, 0);
        send_frame(V_TOTAL, -1, -1, -1);
        send_frame(V_TOTAL, -1, -1, -1);
        checked_frame("relock_hs");
        check("narrow_hs_relocked", {31'd0, locked}, 1);

        // Short frame, then HSync stopped.
        clear_counts();
        send_frame(V_TOTAL - 1, -1, -1, -1);
        send_frame(V_TOTAL, -1, -1, -1);
        check("short_frame_v_err", v_err_cnt, 1);
        check("short_frame_h_err", h_err_cnt, 0);
        check("short_frame_unlocked", {31'd0, locked}, 0);
        clear_counts();
        repeat (1300) tick(1'b1, 1'b1, -1, -1);
        check("hsat_h_err_once", h_err_cnt, 1);
        check("hsat_v_err", v_err_cnt, 0);

        // Relock, then reset mid-frame.
        repeat (4) send_frame(V_TOTAL, -1, -1, -1);
        check("relock_after_stop", {31'd0, locked}, 1);
        sy = int'($urandom_range(VS + VB + 1, V_TOTAL - 2));
        send_frame(V_TOTAL, -1, -1, sy);
        check("locked_before_reset", {31'd0, locked}, 1);
        reset = 1'b0;
        HSync = 1'b1;
        VSync = 1'b1;
        #2;
        check_outputs_zero("async_reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_counts();
        x0 = int'($urandom_range(HS, H_TOTAL - 1));
        send_line(V_TOTAL - 1, x0, H_TOTAL - 1, H_TOTAL, HS, 1'b1);
        send_frame(V_TOTAL, -1, -1, -1);
        send_frame(V_TOTAL, -1, -1, -1);
        check("post_reset_not_yet", {31'd0, locked}, 0);
        checked_frame("post_reset");
        check("post_reset_frame_starts", fs_cnt, 3);
        check("post_reset_locked", {31'd0, locked}, 1);
        check("post_reset_h_err", h_err_cnt, 0);
        check("post_reset_v_err", v_err_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
